dev_reshuffler_arbiter: RTL

// - Shares one dev_reshuffler (transpose unit, 1-cycle registered output, single result slot) among NumReq requesters.
// - Round-robin selects one request per issue, forwards it to the reshuffler and records the owner.
// - Routes the transposed result back to that owner only.
// - Keeps per-requester saturating completion counters for performance monitoring.

---
 rtl/dev_reshuffler_pkg.sv | 20 ++
 rtl/dev_rr_arbiter.sv | 35 +++
 rtl/dev_reshuffler_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/dev_reshuffler_pkg.sv
// Shared types and helpers for the reshuffler arbiter slice.
package dev_reshuffler_pkg;

   localparam int DefNumReq    = 4;
   localparam int DefSpatPar   = 8;
   localparam int DefDataWidth = 64;
   localparam int DefCntWidth  = 16;
   localparam int DefW         = DefSpatPar * DefDataWidth;
   localparam int MaxReq       = 32;

   typedef logic [DefW-1:0]              payload_t;
   typedef logic [$clog2(DefNumReq)-1:0] req_idx_t;
   typedef logic [DefCntWidth-1:0]       cnt_t;

   // Wide one-hot; callers size-cast the result down to their requester count.
   function automatic logic [MaxReq-1:0] onehot(input int unsigned idx);
      onehot = MaxReq'(1) << idx;
   endfunction

endpackage

// File: rtl/dev_rr_arbiter.sv
// Combinational round-robin grant: first valid index at or after ptr, wrapping.
module dev_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] grant,
   output logic                 gnt_valid
);

   localparam int IdxW = $clog2(N);

   int unsigned       pos;
   logic [IdxW-1:0]   pos_idx;

   // Scan from the farthest candidate back to ptr so the closest valid one wins.
   always_comb begin
      grant     = '0;
      gnt_valid = 1'b0;
      pos       = 0;
      pos_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = 32'(ptr) + 32'(k);
         if (pos >= 32'(N)) begin
            pos = pos - 32'(N);
         end
         pos_idx = IdxW'(pos);
         if (valid[pos_idx]) begin
            grant     = pos_idx;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dev_reshuffler_arbiter.sv
// Shares one single-slot reshuffler among NumReq requesters: round-robin issue,
// owner-routed result return and per-requester saturating completion counters.
module dev_reshuffler_arbiter
   import dev_reshuffler_pkg::*;
#(
   parameter int NumReq    = DefNumReq,
   parameter int SpatPar   = DefSpatPar,
   parameter int DataWidth = DefDataWidth,
   parameter int CntWidth  = DefCntWidth
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumReq*SpatPar*DataWidth-1:0] req_data_i,
   input  logic [NumReq-1:0]            req_valid_i,
   output logic [NumReq-1:0]            req_ready_o,
   output logic [SpatPar*DataWidth-1:0] rsp_data_o,
   output logic [NumReq-1:0]            rsp_valid_o,
   input  logic [NumReq-1:0]            rsp_ready_i,
   output logic [SpatPar*DataWidth-1:0] rs_a_o,
   output logic                         rs_a_valid_o,
   input  logic                         rs_a_ready_i,
   input  logic [SpatPar*DataWidth-1:0] rs_z_i,
   input  logic                         rs_z_valid_i,
   output logic                         rs_z_ready_o,
   input  logic                         cnt_clear_i,
   output logic [NumReq*CntWidth-1:0]   cnt_o
);

   localparam int W    = SpatPar * DataWidth;
   localparam int IdxW = $clog2(NumReq);

   logic [IdxW-1:0]     rr_ptr_q;
   logic [IdxW-1:0]     owner_q;
   logic [IdxW-1:0]     gnt;
   logic                gnt_valid;
   logic                slot_free;
   logic                issue;
   logic                drain;
   logic [CntWidth-1:0] cnt_q [NumReq];

   dev_rr_arbiter #(
      .N(NumReq)
   ) u_rr_arbiter (
      .valid     (req_valid_i),
      .ptr       (rr_ptr_q),
      .grant     (gnt),
      .gnt_valid (gnt_valid)
   );

   // The reshuffler overwrites its slot on every input, so only issue when the
   // pending result is absent or leaving this very cycle.
   assign slot_free = !rs_z_valid_i || rs_z_ready_o;
   assign issue     = rst_ni && slot_free && gnt_valid;
   assign drain     = rs_z_valid_i && rs_z_ready_o;

   assign rs_a_valid_o = issue;
   assign rs_a_o       = req_data_i[gnt*W +: W];
   assign req_ready_o  = issue ? NumReq'(onehot(32'(gnt))) : '0;

   assign rsp_data_o   = rs_z_i;
   assign rsp_valid_o  = rs_z_valid_i ? NumReq'(onehot(32'(owner_q))) : '0;
   assign rs_z_ready_o = rs_z_valid_i && rsp_ready_i[owner_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else if (issue && rs_a_ready_i) begin
         owner_q  <= gnt;
         rr_ptr_q <= (gnt == IdxW'(NumReq - 1)) ? '0 : gnt + 1'b1;
      end
   end

   // Clear beats increment; counts stick at all-ones instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumReq; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            if (cnt_clear_i) begin
               cnt_q[i] <= '0;
            end else if (drain && owner_q == IdxW'(i) && cnt_q[i] != '1) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NumReq; g++) begin : g_cnt_out
      assign cnt_o[g*CntWidth +: CntWidth] = cnt_q[g];
   end

endmodule
